// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, bit-period helper and receiver state encoding.
// Used by both the receive and transmit paths.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;

  // Clock cycles per bit period, truncated.
  function automatic int unsigned calc_cpb(input int unsigned clock_frequency,
                                           input int unsigned baud_rate);
    return clock_frequency / baud_rate;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous bit.
// The reset value is a parameter so idle-high pins do not glitch out of reset.
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VALUE;
      sync_q <= RESET_VALUE;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, idle-high line. Bytes leave on a valid/ready port;
// frame_err and overrun are single-cycle status pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 100_000_000,
  parameter int unsigned BAUD_RATE       = 115200
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned CPB   = calc_cpb(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int unsigned HALF  = CPB / 2;
  localparam int unsigned CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);

  if (CPB < 4) begin : g_cpb_check
    $error("uart_rx: CLOCK_FREQUENCY / BAUD_RATE must be at least 4");
  end

  logic                 rxd_s;
  logic                 rxd_prev_q;
  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 stop_done;
  logic                 cnt_wrap;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, frame_err_q, overrun_q;

  sync_2ff #(
    .RESET_VALUE(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rxd),
    .q    (rxd_s)
  );

  assign cnt_wrap = (cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    stop_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        // Edge-triggered so a held-low (break) line cannot restart a frame.
        if (rxd_prev_q && !rxd_s) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rxd_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        cnt_d = cnt_wrap ? '0 : cnt_q + 1'b1;
        if (cnt_wrap) begin
          shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'(DATA_BITS - 1)) state_d = STOP;
        end
      end
      STOP: begin
        cnt_d = cnt_wrap ? '0 : cnt_q + 1'b1;
        if (cnt_wrap) begin
          stop_done = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      rxd_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      rxd_prev_q <= rxd_s;
    end
  end

  // A full output register keeps its byte; a newer one is dropped and flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= stop_done & ~rxd_s;
      overrun_q   <= stop_done & rxd_s & valid_q & ~ready;
      if (stop_done && rxd_s && (!valid_q || ready)) begin
        data_q  <= shift_q;
        valid_q <= 1'b1;
      end else if (valid_q && ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a fast instance (CPB=16) for the functional cases and a
// default-rate instance (CPB=868) driven at +/-2% baud.
module tb_uart_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       rxd_f, ready_f, valid_f, fe_f, ov_f;
  logic [7:0] data_f;
  logic       rxd_d, ready_d, valid_d, fe_d, ov_d;
  logic [7:0] data_d;

  uart_rx #(
    .CLOCK_FREQUENCY(16),
    .BAUD_RATE      (1)
  ) dut_fast (
    .clk      (clk),
    .rst_n    (rst_n),
    .rxd      (rxd_f),
    .data     (data_f),
    .valid    (valid_f),
    .ready    (ready_f),
    .frame_err(fe_f),
    .overrun  (ov_f)
  );

  uart_rx dut_def (
    .clk      (clk),
    .rst_n    (rst_n),
    .rxd      (rxd_d),
    .data     (data_d),
    .valid    (valid_d),
    .ready    (ready_d),
    .frame_err(fe_d),
    .overrun  (ov_d)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitors, sampled on the falling edge.
  int         hs_f = 0, high_f = 0, fec_f = 0, ovc_f = 0, rise_f = -1;
  logic [7:0] hs_data_f = 8'hxx;
  logic       vprev_f = 1'b0;
  int         hs_d = 0, fec_d = 0;
  logic [7:0] hs_data_d = 8'hxx;

  always @(negedge clk) begin
    if (valid_f && !vprev_f) rise_f = cyc;
    if (valid_f) high_f++;
    if (valid_f && ready_f) begin
      hs_f++;
      hs_data_f = data_f;
    end
    if (fe_f) fec_f++;
    if (ov_f) ovc_f++;
    vprev_f = valid_f;
    if (valid_d && ready_d) begin
      hs_d++;
      hs_data_d = data_d;
    end
    if (fe_d) fec_d++;
  end

  int total = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // frame[0] goes on the line first; each bit lasts bc clocks.
  task automatic drive(input logic dflt, input logic [9:0] frame, input int nbits,
                       input int bc);
    for (int i = 0; i < nbits; i++) begin
      if (dflt) rxd_d = frame[i];
      else rxd_f = frame[i];
      tick(bc);
    end
  endtask

  task automatic send_f(input logic [7:0] b, input logic stop_bit);
    drive(1'b0, {stop_bit, b, 1'b0}, 10, 16);
  endtask

  int hs0, hi0, fe0, ov0, t0;

  initial begin
    rst_n   = 1'b0;
    rxd_f   = 1'b1;
    rxd_d   = 1'b1;
    ready_f = 1'b0;
    ready_d = 1'b1;
    tick(5);
    check("reset_data", 32'(data_f), 32'h00);
    check("reset_valid", 32'(valid_f), 32'h0);
    check("reset_frame_err", 32'(fe_f), 32'h0);
    check("reset_overrun", 32'(ov_f), 32'h0);
    rst_n = 1'b1;
    tick(5);

    // Single frame with consumer ready: one-cycle valid at E+HALF+9*CPB+1.
    ready_f = 1'b1;
    hs0 = hs_f; hi0 = high_f; fe0 = fec_f; ov0 = ovc_f;
    t0 = cyc;
    send_f(8'hA5, 1'b1);
    tick(4);
    check("a5_handshakes", 32'(hs_f - hs0), 32'd1);
    check("a5_data", 32'(hs_data_f), 32'hA5);
    check("a5_valid_time", 32'(rise_f), 32'(t0 + 3 + 8 + 144));
    check("a5_valid_width", 32'(high_f - hi0), 32'd1);
    check("a5_no_frame_err", 32'(fec_f - fe0), 32'd0);
    check("a5_no_overrun", 32'(ovc_f - ov0), 32'd0);

    // Back-to-back frames into a stalled consumer.
    ready_f = 1'b0;
    hs0 = hs_f; fe0 = fec_f; ov0 = ovc_f;
    send_f(8'h00, 1'b1);
    send_f(8'hFF, 1'b1);
    send_f(8'h55, 1'b1);
    tick(4);
    check("b2b_valid_held", 32'(valid_f), 32'h1);
    check("b2b_data_kept", 32'(data_f), 32'h00);
    check("b2b_overruns", 32'(ovc_f - ov0), 32'd2);
    check("b2b_no_frame_err", 32'(fec_f - fe0), 32'd0);
    ready_f = 1'b1;
    tick(3);
    ready_f = 1'b0;
    check("b2b_one_handshake", 32'(hs_f - hs0), 32'd1);
    check("b2b_handshake_data", 32'(hs_data_f), 32'h00);
    check("b2b_valid_cleared", 32'(valid_f), 32'h0);

    // Bad stop bit, then a long break, then a clean frame.
    ready_f = 1'b1;
    hs0 = hs_f; hi0 = high_f; fe0 = fec_f;
    send_f(8'h3C, 1'b0);
    tick(80);
    rxd_f = 1'b1;
    tick(32);
    check("ferr_pulses", 32'(fec_f - fe0), 32'd1);
    check("ferr_no_handshake", 32'(hs_f - hs0), 32'd0);
    check("ferr_valid_low", 32'(high_f - hi0), 32'd0);
    send_f(8'h81, 1'b1);
    tick(4);
    check("after_break_handshake", 32'(hs_f - hs0), 32'd1);
    check("after_break_data", 32'(hs_data_f), 32'h81);

    // Short low glitch must be rejected at the start check.
    hs0 = hs_f; fe0 = fec_f; ov0 = ovc_f;
    rxd_f = 1'b0;
    tick(4);
    rxd_f = 1'b1;
    tick(40);
    check("glitch_no_handshake", 32'(hs_f - hs0), 32'd0);
    check("glitch_no_frame_err", 32'(fec_f - fe0), 32'd0);
    check("glitch_no_overrun", 32'(ovc_f - ov0), 32'd0);
    ready_f = 1'b0;
    send_f(8'h42, 1'b1);
    tick(4);
    check("glitch_next_valid", 32'(valid_f), 32'h1);
    check("glitch_next_data", 32'(data_f), 32'h42);

    // Reset mid-frame while a byte is still held.
    drive(1'b0, {1'b1, 8'h99, 1'b0}, 4, 16);
    #2;
    rst_n = 1'b0;
    rxd_f = 1'b1;
    #1;
    check("midrst_valid", 32'(valid_f), 32'h0);
    check("midrst_data", 32'(data_f), 32'h00);
    check("midrst_frame_err", 32'(fe_f), 32'h0);
    check("midrst_overrun", 32'(ov_f), 32'h0);
    tick(3);
    rst_n = 1'b1;
    tick(32);
    hs0 = hs_f;
    ready_f = 1'b1;
    tick(2);
    check("midrst_no_partial", 32'(hs_f - hs0), 32'd0);
    send_f(8'h17, 1'b1);
    tick(4);
    check("midrst_next_handshake", 32'(hs_f - hs0), 32'd1);
    check("midrst_next_data", 32'(hs_data_f), 32'h17);

    // Default rate, transmitter 2% slow then 2% fast.
    hs0 = hs_d; fe0 = fec_d;
    drive(1'b1, {1'b1, 8'h5A, 1'b0}, 10, 885);
    tick(900);
    check("def_slow_handshake", 32'(hs_d - hs0), 32'd1);
    check("def_slow_data", 32'(hs_data_d), 32'h5A);
    check("def_slow_no_frame_err", 32'(fec_d - fe0), 32'd0);
    hs0 = hs_d;
    drive(1'b1, {1'b1, 8'h5A, 1'b0}, 10, 851);
    tick(900);
    check("def_fast_handshake", 32'(hs_d - hs0), 32'd1);
    check("def_fast_data", 32'(hs_data_d), 32'h5A);
    check("def_fast_no_frame_err", 32'(fec_d - fe0), 32'd0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver: 8 data bits, no parity, 1 stop bit (8N1), LSB first, idle-high line. It is the receive half of the board UART and the counterpart of the existing transmit path. It sits between the J5 UART0_RxD pin and any byte consumer, such as the echo loop or a command parser. Received bytes are presented on a valid/ready output port, with framing-error and overrun status pulses.

## Interface
- CLOCK_FREQUENCY, 100_000_000: clk frequency in Hz.
- BAUD_RATE, 115200: line bit rate.
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- rxd  in  1  raw serial input, asynchronous to clk.
- data  out  8  received byte; stable while valid=1.
- valid  out  1  data holds an unconsumed byte.
- ready  in  1  consumer accepts data when valid & ready at a clock edge.
- frame_err  out  1  one-cycle pulse: the stop bit was sampled low.
- overrun  out  1  one-cycle pulse: a completed byte was dropped because the output was still full.

## Operation
- Derived constants:
  - CPB = CLOCK_FREQUENCY / BAUD_RATE, integer truncation; 868 at the defaults.
  - HALF = CPB / 2, truncated.
  - Elaboration must fail if CPB < 4.
- rxd passes through a 2-FF synchronizer; both flops reset to 1. The synchronized signal is rxd_s.
- FSM states:
  - IDLE: waits for a falling edge of rxd_s (previous 1, current 0). A line held low (break) never retriggers.
  - START: counts to HALF and samples rxd_s.
    - Sample 1: glitch; go to IDLE with no status output.
    - Sample 0: go to DATA.
  - DATA: samples every CPB cycles, shifts LSB first, eight samples, then goes to STOP.
  - STOP: samples once after CPB cycles.
    - Sample 1: byte complete.
    - Sample 0: pulse frame_err; the byte is discarded.
    - Either way, return to IDLE.
- Output register:
  - On a completed byte with valid=0, or with valid & ready in the same cycle: load data and set valid=1.
  - On a completed byte with valid=1 & ready=0: pulse overrun. The new byte is dropped and the old data and valid are kept.
  - valid & ready with no completion in that cycle: valid goes to 0 and data keeps its last value.
- The bit counter is 3 bits. The baud counter is sized by clog2(CPB), counts 0..CPB-1 and wraps.
- Reset values (also after reset asserted mid-frame, with no partial byte emitted): state=IDLE, data=8'h00, valid=0, frame_err=0, overrun=0, counters 0, synchronizer 1.

## Timing
- Let E be the first cycle rxd_s=0 in IDLE; this is 2 cycles after the pin transition is first registered.
- Start check at E+HALF.
- Data bit i (i=0..7) is sampled at E+HALF+(i+1)*CPB.
- Stop bit is sampled at E+HALF+9*CPB.
- valid, frame_err and overrun become visible in the cycle after the stop sample.
- The FSM is in IDLE in the cycle after the stop sample. Back-to-back frames with no idle time are received without loss, provided the consumer takes each byte within one frame time.
- ready has no combinational path to any output.

## Structure
- Shared package uart_pkg holds:
  - DATA_BITS = 8
  - a CPB computation function, shared with the transmitter
  - state encodings IDLE/START/DATA/STOP
- One sub-module, sync_2ff (generic two-flop bit synchronizer, reset value parameterized). It is reusable for other pin inputs.

## Test plan
Use CLOCK_FREQUENCY=16, BAUD_RATE=1 (CPB=16) for speed, plus one run at the defaults.
- Single frame 0xA5 with ready=1 -> data=0xA5, valid high for exactly 1 cycle at E+8+144+1, no status pulses.
- Frames 0x00, 0xFF, 0x55 sent back-to-back, ready=0 until all are sent, then ready=1:
  - data=0x00 retained, two overrun pulses;
  - one 0x00 handshake after ready=1, then valid=0.
- Frame 0x3C with stop bit driven 0 -> frame_err pulses once, valid stays 0. The line is then held low 5 bit times: no further activity. Return high, send 0x81 -> received correctly.
- Low glitch of 4 cycles on an idle line -> FSM returns to IDLE with no outputs. A following 0x42 is received.
- rst_n pulsed low mid-DATA of 0x99 -> all outputs 0 immediately (asynchronous), no partial byte. The next full frame 0x17 is received correctly.
- Defaults (CPB=868), frame 0x5A sent at baud ±2% -> 0x5A received, no frame_err.
